// File: rtl/mesh_xy_router_pkg.sv
// Shared definitions for the XY mesh router: port indices, hop-field
// widths and helpers that read and decrement a 3-bit {dir, count} field.
package router_pkg;

  localparam int NUM_PORTS = 5;
  localparam int HOP_W     = 2;

  // Port index order also defines round-robin priority order.
  typedef enum logic [2:0] {
    P_W  = 3'd0,
    P_E  = 3'd1,
    P_N  = 3'd2,
    P_S  = 3'd3,
    P_PE = 3'd4
  } port_e;

  // Remaining hop count of a {dir, count} field.
  function automatic logic [HOP_W-1:0] hop_count(input logic [HOP_W:0] fld);
    return fld[HOP_W-1:0];
  endfunction

  // Direction bit of a {dir, count} field.
  function automatic logic hop_dir(input logic [HOP_W:0] fld);
    return fld[HOP_W];
  endfunction

  // One hop consumed: count minus one, direction bit untouched.
  function automatic logic [HOP_W:0] hop_dec(input logic [HOP_W:0] fld);
    return {fld[HOP_W], fld[HOP_W-1:0] - HOP_W'(1)};
  endfunction

endpackage

// File: rtl/mesh_xy_router_rr_arbiter5.sv
// Five-way round-robin arbiter. The search starts at the pointer; after a
// grant the pointer moves just past the winner so it gets lowest priority.
module rr_arbiter5
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 en_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  logic [2:0]           ptr_q;
  logic [2:0]           ptr_d;
  logic [NUM_PORTS-1:0] rot_s;
  logic [3:0]           idx_s;
  logic [3:0]           sum_s;
  logic [2:0]           off_s;
  logic [2:0]           win_s;
  logic                 found_s;

  // Rotate requests so bit 0 is the requester at the pointer, then pick the
  // first set bit and map it back to an absolute port index.
  always_comb begin
    rot_s = '0;
    idx_s = 4'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx_s = {1'b0, ptr_q} + 4'(k);
      if (idx_s >= 4'd5) begin
        idx_s = idx_s - 4'd5;
      end else begin
        idx_s = idx_s;
      end
      rot_s[k] = req_i[idx_s[2:0]];
    end
    found_s = |rot_s;
    off_s   = 3'd0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = 3'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, ptr_q} + {1'b0, off_s};
    if (sum_s >= 4'd5) begin
      win_s = 3'(sum_s - 4'd5);
    end else begin
      win_s = sum_s[2:0];
    end
  end

  // Grant and next pointer; nothing moves when the output cannot accept.
  always_comb begin
    if (en_i && found_s) begin
      gnt_o = 5'b00001 << win_s;
      ptr_d = (win_s == 3'd4) ? 3'd0 : win_s + 3'd1;
    end else begin
      gnt_o = 5'b00000;
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mesh_xy_router.sv
// Five-port XY dimension-order mesh router: 2-entry FIFO per input, route
// computed on each FIFO head, one registered output plus round-robin
// arbiter per output.
module mesh_xy_router
  import router_pkg::*;
#(
  parameter int WIDTH     = 15,
  parameter int X_HOP_LOC = 4,
  parameter int Y_HOP_LOC = 7,
  parameter int NODE_NUM  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] w_in_data,
  input  logic             w_in_valid,
  output logic             w_in_ready,
  output logic [WIDTH-1:0] w_out_data,
  output logic             w_out_valid,
  input  logic             w_out_ready,
  input  logic [WIDTH-1:0] e_in_data,
  input  logic             e_in_valid,
  output logic             e_in_ready,
  output logic [WIDTH-1:0] e_out_data,
  output logic             e_out_valid,
  input  logic             e_out_ready,
  input  logic [WIDTH-1:0] n_in_data,
  input  logic             n_in_valid,
  output logic             n_in_ready,
  output logic [WIDTH-1:0] n_out_data,
  output logic             n_out_valid,
  input  logic             n_out_ready,
  input  logic [WIDTH-1:0] s_in_data,
  input  logic             s_in_valid,
  output logic             s_in_ready,
  output logic [WIDTH-1:0] s_out_data,
  output logic             s_out_valid,
  input  logic             s_out_ready,
  input  logic [WIDTH-1:0] pe_in_data,
  input  logic             pe_in_valid,
  output logic             pe_in_ready,
  output logic [WIDTH-1:0] pe_out_data,
  output logic             pe_out_valid,
  input  logic             pe_out_ready
);

  // Node id is informational only; the empty block just anchors the name.
  if (NODE_NUM >= 0) begin : g_node_tag
  end

  logic [WIDTH-1:0]     in_data_s   [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_valid_s;
  logic [NUM_PORTS-1:0] out_ready_s;

  logic [WIDTH-1:0]     fifo_mem_q  [NUM_PORTS][2];
  logic [NUM_PORTS-1:0] rd_ptr_q;
  logic [NUM_PORTS-1:0] wr_ptr_q;
  logic [1:0]           count_q     [NUM_PORTS];
  logic [1:0]           count_d     [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_ready_q;
  logic [NUM_PORTS-1:0] in_ready_d;
  logic [NUM_PORTS-1:0] push_s;
  logic [NUM_PORTS-1:0] pop_s;
  logic [NUM_PORTS-1:0] not_empty_s;
  logic [WIDTH-1:0]     head_s      [NUM_PORTS];

  logic [HOP_W:0]       x_fld_s     [NUM_PORTS];
  logic [HOP_W:0]       y_fld_s     [NUM_PORTS];
  logic [WIDTH-1:0]     rw_flit_s   [NUM_PORTS];
  port_e                route_s     [NUM_PORTS];

  logic [NUM_PORTS-1:0] req_s       [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_s       [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_en_s;

  logic [NUM_PORTS-1:0] out_valid_q;
  logic [NUM_PORTS-1:0] out_valid_d;
  logic [WIDTH-1:0]     out_data_q  [NUM_PORTS];
  logic [WIDTH-1:0]     out_data_d  [NUM_PORTS];

  assign in_data_s[P_W]  = w_in_data;
  assign in_data_s[P_E]  = e_in_data;
  assign in_data_s[P_N]  = n_in_data;
  assign in_data_s[P_S]  = s_in_data;
  assign in_data_s[P_PE] = pe_in_data;
  assign in_valid_s  = {pe_in_valid, s_in_valid, n_in_valid, e_in_valid, w_in_valid};
  assign out_ready_s = {pe_out_ready, s_out_ready, n_out_ready, e_out_ready, w_out_ready};

  assign w_in_ready  = in_ready_q[P_W];
  assign e_in_ready  = in_ready_q[P_E];
  assign n_in_ready  = in_ready_q[P_N];
  assign s_in_ready  = in_ready_q[P_S];
  assign pe_in_ready = in_ready_q[P_PE];

  assign w_out_data  = out_data_q[P_W];
  assign e_out_data  = out_data_q[P_E];
  assign n_out_data  = out_data_q[P_N];
  assign s_out_data  = out_data_q[P_S];
  assign pe_out_data = out_data_q[P_PE];
  assign {pe_out_valid, s_out_valid, n_out_valid, e_out_valid, w_out_valid} = out_valid_q;

  // FIFO status: push only when advertised ready, head is the read slot.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      push_s[p]      = in_valid_s[p] && in_ready_q[p];
      not_empty_s[p] = (count_q[p] != 2'd0);
      head_s[p]      = fifo_mem_q[p][rd_ptr_q[p]];
    end
  end

  // XY route of each head flit and the flit rewritten for the next hop.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      x_fld_s[p]   = head_s[p][X_HOP_LOC +: (HOP_W + 1)];
      y_fld_s[p]   = head_s[p][Y_HOP_LOC +: (HOP_W + 1)];
      rw_flit_s[p] = head_s[p];
      route_s[p]   = P_PE;
      if (hop_count(x_fld_s[p]) != 2'd0) begin
        route_s[p] = hop_dir(x_fld_s[p]) ? P_W : P_E;
        rw_flit_s[p][X_HOP_LOC +: (HOP_W + 1)] = hop_dec(x_fld_s[p]);
      end else if (hop_count(y_fld_s[p]) != 2'd0) begin
        route_s[p] = hop_dir(y_fld_s[p]) ? P_S : P_N;
        rw_flit_s[p][Y_HOP_LOC +: (HOP_W + 1)] = hop_dec(y_fld_s[p]);
      end else begin
        route_s[p] = P_PE;
      end
    end
  end

  // Request matrix: output o sees every non-empty input whose head routes to o.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        req_s[o][p] = not_empty_s[p] && (int'(route_s[p]) == o);
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    assign arb_en_s[o] = !out_valid_q[o] || out_ready_s[o];
    rr_arbiter5 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (req_s[o]),
      .en_i  (arb_en_s[o]),
      .gnt_o (gnt_s[o])
    );
  end

  // Pop an input when any output granted it; each head targets one output.
  always_comb begin
    pop_s = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        pop_s[p] = pop_s[p] | gnt_s[o][p];
      end
    end
  end

  // Occupancy after this edge; ready is registered from it.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      count_d[p]    = count_q[p] + {1'b0, push_s[p]} - {1'b0, pop_s[p]};
      in_ready_d[p] = (count_d[p] != 2'd2);
    end
  end

  // Output register next state: load winner, else drain, else hold.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_data_d[o] = out_data_q[o];
      if (out_valid_q[o] && out_ready_s[o]) begin
        out_valid_d[o] = 1'b0;
      end else begin
        out_valid_d[o] = out_valid_q[o];
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt_s[o][p]) begin
          out_valid_d[o] = 1'b1;
          out_data_d[o]  = rw_flit_s[p];
        end else begin
          out_data_d[o]  = out_data_d[o];
        end
      end
    end
  end

  // Input FIFO storage, pointers, occupancy and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      in_ready_q <= '1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        count_q[p] <= 2'd0;
      end
    end else begin
      in_ready_q <= in_ready_d;
      rd_ptr_q   <= rd_ptr_q ^ pop_s;
      wr_ptr_q   <= wr_ptr_q ^ push_s;
      for (int p = 0; p < NUM_PORTS; p++) begin
        count_q[p] <= count_d[p];
        if (push_s[p]) begin
          fifo_mem_q[p][wr_ptr_q[p]] <= in_data_s[p];
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_data_q[o] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_data_q[o] <= out_data_d[o];
      end
    end
  end

endmodule

// File: tb/tb_mesh_xy_router.sv
// Directed plus random checks of mesh_xy_router against a queue-based
// behavioural model of the routing, arbitration and handshake rules.
module tb_mesh_xy_router;

  logic        clk;
  logic        rst;
  logic [14:0] idata [5];
  logic        ivld  [5];
  logic        ordy  [5];

  logic [14:0] w_od, e_od, n_od, s_od, pe_od;
  logic        w_ov, e_ov, n_ov, s_ov, pe_ov;
  logic        w_ir, e_ir, n_ir, s_ir, pe_ir;

  int errors = 0;
  int checks = 0;

  string pn [5] = '{"w", "e", "n", "s", "pe"};

  // Reference state: input queues, output registers, round-robin pointers.
  logic [14:0] mq   [5][$];
  bit          mov  [5];
  logic [14:0] mod  [5];
  int          mptr [5];

  mesh_xy_router dut (
    .clk(clk), .rst(rst),
    .w_in_data(idata[0]),  .w_in_valid(ivld[0]),  .w_in_ready(w_ir),
    .w_out_data(w_od),     .w_out_valid(w_ov),    .w_out_ready(ordy[0]),
    .e_in_data(idata[1]),  .e_in_valid(ivld[1]),  .e_in_ready(e_ir),
    .e_out_data(e_od),     .e_out_valid(e_ov),    .e_out_ready(ordy[1]),
    .n_in_data(idata[2]),  .n_in_valid(ivld[2]),  .n_in_ready(n_ir),
    .n_out_data(n_od),     .n_out_valid(n_ov),    .n_out_ready(ordy[2]),
    .s_in_data(idata[3]),  .s_in_valid(ivld[3]),  .s_in_ready(s_ir),
    .s_out_data(s_od),     .s_out_valid(s_ov),    .s_out_ready(ordy[3]),
    .pe_in_data(idata[4]), .pe_in_valid(ivld[4]), .pe_in_ready(pe_ir),
    .pe_out_data(pe_od),   .pe_out_valid(pe_ov),  .pe_out_ready(ordy[4])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // XY rule: destination index and the flit as it leaves this node.
  task automatic route(input logic [14:0] f, output int dest, output logic [14:0] nf);
    int x;
    int y;
    x = (int'(f) >> 4) & 7;
    y = (int'(f) >> 7) & 7;
    if ((x & 3) != 0) begin
      dest = ((x & 4) != 0) ? 0 : 1;
      nf   = f - 15'd16;
    end else if ((y & 3) != 0) begin
      dest = ((y & 4) != 0) ? 3 : 2;
      nf   = f - 15'd128;
    end else begin
      dest = 4;
      nf   = f;
    end
  endtask

  // Advance the reference by one rising edge using the inputs present at it.
  task automatic model_edge();
    bit          pre_rdy [5];
    bit          popd    [5];
    int          dest    [5];
    logic [14:0] nf      [5];
    bit          got;
    int          i;
    if (rst) begin
      for (int p = 0; p < 5; p++) begin
        mq[p].delete();
        mov[p]  = 1'b0;
        mod[p]  = 15'd0;
        mptr[p] = 0;
      end
      return;
    end
    for (int p = 0; p < 5; p++) begin
      pre_rdy[p] = (mq[p].size() < 2);
      popd[p]    = 1'b0;
      dest[p]    = -1;
      nf[p]      = 15'd0;
      if (mq[p].size() > 0) route(mq[p][0], dest[p], nf[p]);
    end
    for (int o = 0; o < 5; o++) begin
      if (!mov[o] || ordy[o]) begin
        mov[o] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 5; k++) begin
          i = (mptr[o] + k) % 5;
          if (!got && dest[i] == o) begin
            got     = 1'b1;
            mov[o]  = 1'b1;
            mod[o]  = nf[i];
            mptr[o] = (i + 1) % 5;
            popd[i] = 1'b1;
          end
        end
      end
    end
    for (int p = 0; p < 5; p++) begin
      if (popd[p]) void'(mq[p].pop_front());
      if (ivld[p] && pre_rdy[p]) mq[p].push_back(idata[p]);
    end
  endtask

  // Compare every output and ready against the reference.
  task automatic check_all();
    logic [14:0] od [5];
    logic        ov [5];
    logic        ir [5];
    od = '{w_od, e_od, n_od, s_od, pe_od};
    ov = '{w_ov, e_ov, n_ov, s_ov, pe_ov};
    ir = '{w_ir, e_ir, n_ir, s_ir, pe_ir};
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("%s_out_valid", pn[p]), 15'(ov[p]), 15'(mov[p]));
      if (mov[p]) chk($sformatf("%s_out_data", pn[p]), od[p], mod[p]);
      chk($sformatf("%s_in_ready", pn[p]), 15'(ir[p]), 15'(mq[p].size() < 2));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 5; p++) begin
      ivld[p]  = 1'b0;
      idata[p] = 15'd0;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int p = 0; p < 5; p++) ordy[p] = 1'b1;

    // Reset state.
    cycle();
    chk("rst_w_out_valid", 15'(w_ov), 15'd0);
    chk("rst_pe_out_valid", 15'(pe_ov), 15'd0);
    chk("rst_e_out_data", e_od, 15'd0);
    chk("rst_n_in_ready", 15'(n_ir), 15'd1);
    rst = 1'b0;
    cycle();

    // Eject: zero counts go to the PE unchanged.
    idata[2] = 15'h7C00; ivld[2] = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    chk("eject_valid", 15'(pe_ov), 15'd1);
    chk("eject_data", pe_od, 15'h7C00);
    chk("eject_no_s", 15'(s_ov), 15'd0);
    cycle();

    // X hop east.
    idata[0] = 15'h0025; ivld[0] = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    chk("xhop_data", e_od, 15'h0015);
    cycle();

    // Y hop south from the PE.
    idata[4] = 15'h0283; ivld[4] = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    chk("yhop_data", s_od, 15'h0203);
    cycle();

    // Contention on the PE output, twice.
    for (int r = 0; r < 2; r++) begin
      idata[0] = 15'h0001; ivld[0] = 1'b1;
      idata[1] = 15'h0002; ivld[1] = 1'b1;
      cycle();
      idle_inputs();
      cycle();
      if (r == 0) chk("cont_first", pe_od, 15'h0001);
      cycle();
      if (r == 0) chk("cont_second", pe_od, 15'h0002);
      cycle();
    end

    // Backpressure on east output while streaming into west.
    ordy[1] = 1'b0;
    ivld[0] = 1'b1;
    idata[0] = 15'h0015; cycle();
    idata[0] = 15'h0011; cycle();
    idata[0] = 15'h0012; cycle();
    idata[0] = 15'h0013; cycle();
    cycle();
    chk("bp_w_in_ready", 15'(w_ir), 15'd0);
    chk("bp_e_out_valid", 15'(e_ov), 15'd1);
    chk("bp_e_out_data", e_od, 15'h0005);
    idle_inputs();
    ordy[1] = 1'b1;
    cycle();
    chk("bp_drain1", e_od, 15'h0001);
    cycle();
    chk("bp_drain2", e_od, 15'h0002);
    cycle();
    chk("bp_drained", 15'(e_ov), 15'd0);
    cycle();

    // Reset while flits are buffered.
    for (int p = 0; p < 5; p++) ordy[p] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 5; p++) begin
        ivld[p]  = 1'b1;
        idata[p] = 15'($urandom);
      end
      cycle();
    end
    rst = 1'b1;
    cycle();
    chk("mrst_e_out_valid", 15'(e_ov), 15'd0);
    chk("mrst_pe_out_valid", 15'(pe_ov), 15'd0);
    chk("mrst_w_in_ready", 15'(w_ir), 15'd1);
    chk("mrst_s_in_ready", 15'(s_ir), 15'd1);
    rst = 1'b0;
    idle_inputs();
    for (int p = 0; p < 5; p++) ordy[p] = 1'b1;
    for (int c = 0; c < 4; c++) cycle();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 5; p++) begin
        ivld[p]  = ($urandom_range(0, 99) < 60);
        idata[p] = 15'($urandom);
        ordy[p]  = ($urandom_range(0, 99) < 70);
      end
      cycle();
    end
    idle_inputs();
    for (int p = 0; p < 5; p++) ordy[p] = 1'b1;
    for (int c = 0; c < 12; c++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
